// File: rtl/scratchpad_req_ctrl_pkg.sv
// Shared encodings, FSM state type and size helpers for the scratchpad request front-end.
package scratchpad_pkg;

  // Access size encodings carried on req_len / sp_len
  localparam logic [1:0] LEN_B = 2'b00;
  localparam logic [1:0] LEN_H = 2'b01;
  localparam logic [1:0] LEN_W = 2'b10;
  localparam logic [1:0] LEN_D = 2'b11;

  // Response error codes
  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_RANGE = 2'b01;
  localparam logic [1:0] ERR_ALIGN = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Number of bytes touched by an access of the given size
  function automatic logic [3:0] len_bytes(input logic [1:0] len);
    return 4'(4'd1 << len);
  endfunction

  // Keep only the bytes of the access size, zero-extended to 64 bits
  function automatic logic [63:0] mask_rdata(input logic [63:0] d, input logic [1:0] len);
    case (len)
      LEN_B:   return {56'd0, d[7:0]};
      LEN_H:   return {48'd0, d[15:0]};
      LEN_W:   return {32'd0, d[31:0]};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/scratchpad_req_ctrl_if.sv
// Core-side request/response channel of the scratchpad request front-end.
interface scratchpad_req_ctrl_if #(
  parameter int unsigned TAG_W = 8
) ();

  logic             req_valid;
  logic             req_ready;
  logic             req_write;
  logic [63:0]      req_addr;
  logic [1:0]       req_len;
  logic [63:0]      req_wdata;
  logic [TAG_W-1:0] req_tag;

  logic             resp_valid;
  logic             resp_ready;
  logic [63:0]      resp_rdata;
  logic [1:0]       resp_err;
  logic [TAG_W-1:0] resp_tag;

  // Requester side (core model)
  modport master (
    output req_valid, req_write, req_addr, req_len, req_wdata, req_tag, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err, resp_tag
  );

  // Controller side
  modport slave (
    input  req_valid, req_write, req_addr, req_len, req_wdata, req_tag, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err, resp_tag
  );

endinterface

// File: rtl/scratchpad_req_ctrl_sp_addr_check.sv
// Combinational range and alignment check of a request against the scratchpad window.
module sp_addr_check
  import scratchpad_pkg::*;
#(
  parameter logic [63:0] SCRATCHPAD_BASE = 64'h0000_0000_0300_0000,
  parameter logic [64:0] SP_SIZE         = 65'h8000
) (
  input  logic [63:0] addr,
  input  logic [1:0]  len,
  output logic [1:0]  err
);

  logic [3:0]  bytes;
  logic [64:0] off;
  logic [64:0] end_off;
  logic        out_of_range;
  logic        misaligned;

  // 65-bit offset: bit 64 flags addr below base, and the end check catches 2^64 wrap
  always_comb begin
    bytes        = len_bytes(len);
    off          = {1'b0, addr} - {1'b0, SCRATCHPAD_BASE};
    end_off      = off + 65'(bytes);
    out_of_range = off[64] | (end_off > SP_SIZE);
    misaligned   = (addr[2:0] & (3'(bytes) - 3'd1)) != 3'd0;
    if (out_of_range) begin
      err = ERR_RANGE;
    end else if (misaligned) begin
      err = ERR_ALIGN;
    end else begin
      err = ERR_OK;
    end
  end

endmodule

// File: rtl/scratchpad_req_ctrl.sv
// Single-outstanding request front-end: checks, issues to the scratchpad, returns tagged responses.
module scratchpad_req_ctrl
  import scratchpad_pkg::*;
#(
  parameter int unsigned CHUNK_SIZE      = 4096,
  parameter int unsigned NUM_CHUNKS      = 8,
  parameter logic [63:0] SCRATCHPAD_BASE = 64'h0000_0000_0300_0000,
  parameter int unsigned RD_LATENCY      = 1,
  parameter int unsigned TAG_W           = 8
) (
  input  logic                 clk,
  input  logic                 rst_l,
  scratchpad_req_ctrl_if.slave bus,
  output logic                 sp_en,
  output logic                 sp_write,
  output logic [63:0]          sp_addr,
  output logic [1:0]           sp_len,
  output logic [63:0]          sp_wdata,
  input  logic [63:0]          sp_rdata
);

  localparam logic [64:0] SP_SIZE = 65'(CHUNK_SIZE) * 65'(NUM_CHUNKS);
  localparam int unsigned CNT_W   = 2;

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       req_err;

  sp_addr_check #(
    .SCRATCHPAD_BASE (SCRATCHPAD_BASE),
    .SP_SIZE         (SP_SIZE)
  ) u_addr_check (
    .addr (bus.req_addr),
    .len  (bus.req_len),
    .err  (req_err)
  );

  // Request/response FSM; all outputs registered, sp_* payload only changes when a legal access issues
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      bus.req_ready   <= 1'b0;
      bus.resp_valid  <= 1'b0;
      bus.resp_rdata  <= '0;
      bus.resp_err    <= ERR_OK;
      bus.resp_tag    <= '0;
      sp_en           <= 1'b0;
      sp_write        <= 1'b0;
      sp_addr         <= '0;
      sp_len          <= LEN_B;
      sp_wdata        <= '0;
    end else begin
      sp_en    <= 1'b0;
      sp_write <= 1'b0;
      case (state)
        ST_IDLE: begin
          bus.req_ready <= 1'b1;
          if (bus.req_valid && bus.req_ready) begin
            bus.req_ready  <= 1'b0;
            bus.resp_tag   <= TAG_W'(bus.req_tag);
            bus.resp_err   <= req_err;
            bus.resp_rdata <= '0;
            if (req_err != ERR_OK) begin
              bus.resp_valid <= 1'b1;
              state          <= ST_RESP;
            end else begin
              sp_en    <= 1'b1;
              sp_write <= bus.req_write;
              sp_addr  <= bus.req_addr;
              sp_len   <= bus.req_len;
              sp_wdata <= bus.req_wdata;
              state    <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (sp_write) begin
            bus.resp_valid <= 1'b1;
            state          <= ST_RESP;
          end else begin
            cnt   <= CNT_W'(RD_LATENCY - 1);
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            bus.resp_rdata <= mask_rdata(sp_rdata, sp_len);
            bus.resp_valid <= 1'b1;
            state          <= ST_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            bus.req_ready  <= 1'b1;
            state          <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scratchpad_req_ctrl.sv
// Directed bench: two controllers (read latency 1 and 3) with behavioural scratchpad models.
module tb_scratchpad_req_ctrl;
  import scratchpad_pkg::*;

  localparam logic [63:0] BASE = 64'h0000_0000_0300_0000;
  localparam logic [63:0] SPSZ = 64'h0000_0000_0000_8000;

  typedef struct {
    bit          dut;   // 0: latency-1 instance, 1: latency-3 instance
    logic        write;
    logic [63:0] addr;
    logic [1:0]  len;
    logic [63:0] wdata;
    logic [7:0]  tag;
    logic [1:0]  err;
    logic [63:0] rdata;
    int          lat;
    int          spen;
    int          stall;
  } vec_t;

  logic clk = 1'b0;
  logic rst_l;
  always #5 clk = ~clk;

  // Shared stimulus, steered to one instance by sel
  bit          sel;
  logic        req_valid, req_write, resp_ready;
  logic [63:0] req_addr, req_wdata;
  logic [1:0]  req_len;
  logic [7:0]  req_tag;

  scratchpad_req_ctrl_if #(.TAG_W(8)) if1 ();
  scratchpad_req_ctrl_if #(.TAG_W(8)) if3 ();

  assign if1.req_valid  = req_valid & ~sel;
  assign if3.req_valid  = req_valid & sel;
  assign if1.req_write  = req_write;
  assign if3.req_write  = req_write;
  assign if1.req_addr   = req_addr;
  assign if3.req_addr   = req_addr;
  assign if1.req_len    = req_len;
  assign if3.req_len    = req_len;
  assign if1.req_wdata  = req_wdata;
  assign if3.req_wdata  = req_wdata;
  assign if1.req_tag    = req_tag;
  assign if3.req_tag    = req_tag;
  assign if1.resp_ready = resp_ready;
  assign if3.resp_ready = resp_ready;

  logic        sp_en1, sp_write1, sp_en3, sp_write3;
  logic [63:0] sp_addr1, sp_wdata1, rd1, sp_addr3, sp_wdata3, rd3;
  logic [1:0]  sp_len1, sp_len3;

  scratchpad_req_ctrl #(.RD_LATENCY(1), .TAG_W(8)) u_dut1 (
    .clk(clk), .rst_l(rst_l), .bus(if1),
    .sp_en(sp_en1), .sp_write(sp_write1), .sp_addr(sp_addr1),
    .sp_len(sp_len1), .sp_wdata(sp_wdata1), .sp_rdata(rd1)
  );

  scratchpad_req_ctrl #(.RD_LATENCY(3), .TAG_W(8)) u_dut3 (
    .clk(clk), .rst_l(rst_l), .bus(if3),
    .sp_en(sp_en3), .sp_write(sp_write3), .sp_addr(sp_addr3),
    .sp_len(sp_len3), .sp_wdata(sp_wdata3), .sp_rdata(rd3)
  );

  // Latency-1 scratchpad: byte-lane writes, reads return the word shifted to the addressed lane.
  // Read data is only valid in the one cycle after the strobe; otherwise it is poison.
  logic [63:0] mem [0:4095];
  always @(posedge clk) begin
    if (sp_en1 && sp_write1) begin
      for (int b = 0; b < 8; b++) begin
        if (b >= int'(sp_addr1[2:0]) && b < int'(sp_addr1[2:0]) + (1 << sp_len1))
          mem[sp_addr1[14:3]][8*b +: 8] <= sp_wdata1[8*(b - int'(sp_addr1[2:0])) +: 8];
      end
    end
    rd1 <= (sp_en1 && !sp_write1) ? (mem[sp_addr1[14:3]] >> (8 * sp_addr1[2:0]))
                                  : 64'hBAD1_BAD1_BAD1_BAD1;
  end

  // Latency-3 scratchpad: data is a fixed function of the address, valid 3 cycles after the strobe
  logic [63:0] p0, p1;
  always @(posedge clk) begin
    p0  <= (sp_en3 && !sp_write3) ? {sp_addr3[31:0] ^ 32'hA5A5_A5A5, sp_addr3[31:0]}
                                  : 64'hBAD3_BAD3_BAD3_BAD3;
    p1  <= p0;
    rd3 <= p1;
  end

  // Observed view of the selected instance
  logic        m_req_ready, m_resp_valid, m_sp_en, m_sp_write;
  logic [63:0] m_resp_rdata, m_sp_addr;
  logic [1:0]  m_resp_err;
  logic [7:0]  m_resp_tag;
  assign m_req_ready  = sel ? if3.req_ready  : if1.req_ready;
  assign m_resp_valid = sel ? if3.resp_valid : if1.resp_valid;
  assign m_resp_rdata = sel ? if3.resp_rdata : if1.resp_rdata;
  assign m_resp_err   = sel ? if3.resp_err   : if1.resp_err;
  assign m_resp_tag   = sel ? if3.resp_tag   : if1.resp_tag;
  assign m_sp_en      = sel ? sp_en3         : sp_en1;
  assign m_sp_write   = sel ? sp_write3      : sp_write1;
  assign m_sp_addr    = sel ? sp_addr3       : sp_addr1;

  int spen_cnt;
  always @(posedge clk) if (m_sp_en) spen_cnt <= spen_cnt + 1;

  int checks;
  int failures;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit d, input logic w, input logic [63:0] a, input logic [1:0] l,
                              input logic [63:0] wd, input logic [7:0] t, input logic [1:0] e,
                              input logic [63:0] rd, input int lat, input int spen, input int stall);
    vec_t v;
    v.dut = d; v.write = w; v.addr = a; v.len = l; v.wdata = wd; v.tag = t;
    v.err = e; v.rdata = rd; v.lat = lat; v.spen = spen; v.stall = stall;
    return v;
  endfunction

  // Issue one request, check accept, strobe, latency and response, then complete the handshake
  task automatic run_vec(input vec_t v, input int idx);
    int n;
    int spen0;
    string nm;
    logic [63:0] h_rdata;
    logic [1:0]  h_err;
    logic [7:0]  h_tag;
    nm = $sformatf("v%0d", idx);
    sel = v.dut; req_write = v.write; req_addr = v.addr; req_len = v.len;
    req_wdata = v.wdata; req_tag = v.tag; req_valid = 1'b1; resp_ready = 1'b0;
    #1;
    n = 0;
    while (!m_req_ready && n < 20) begin @(negedge clk); n++; end
    if (!m_req_ready) begin
      chk({nm, " accept timeout"}, 64'(m_req_ready), 64'd1);
      req_valid = 1'b0;
      return;
    end
    spen0 = spen_cnt;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    while (!m_resp_valid && n < 20) begin
      if (m_sp_en) begin
        chk({nm, " sp_addr"}, m_sp_addr, v.addr);
        chk({nm, " sp_write"}, 64'(m_sp_write), 64'(v.write));
      end
      @(negedge clk);
      n++;
    end
    chk({nm, " latency"}, 64'(n), 64'(v.lat));
    chk({nm, " resp_err"}, 64'(m_resp_err), 64'(v.err));
    chk({nm, " resp_rdata"}, m_resp_rdata, v.rdata);
    chk({nm, " resp_tag"}, 64'(m_resp_tag), 64'(v.tag));
    chk({nm, " sp_en cycles"}, 64'(spen_cnt - spen0), 64'(v.spen));
    h_rdata = m_resp_rdata; h_err = m_resp_err; h_tag = m_resp_tag;
    // Backpressure: a new request is presented but must not be taken while the response waits
    for (int s = 0; s < v.stall; s++) begin
      req_valid = 1'b1;
      @(negedge clk);
      chk({nm, " stall resp_valid"}, 64'(m_resp_valid), 64'd1);
      chk({nm, " stall rdata"}, m_resp_rdata, h_rdata);
      chk({nm, " stall err/tag"}, 64'({h_err, h_tag}), 64'({m_resp_err, m_resp_tag}));
      chk({nm, " stall req_ready"}, 64'(m_req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid = 1'b0;
    chk({nm, " post resp_valid"}, 64'(m_resp_valid), 64'd0);
    chk({nm, " post req_ready"}, 64'(m_req_ready), 64'd1);
    chk({nm, " no extra sp_en"}, 64'(spen_cnt - spen0), 64'(v.spen));
  endtask

  // Start a load, then pull reset between edges after 'extra' more cycles
  task automatic reset_mid(input bit d, input int extra, input logic pre_en, input logic pre_rv,
                           input string nm);
    int n;
    bit stale;
    sel = d; req_write = 1'b0; req_addr = BASE + 64'h100; req_len = LEN_D;
    req_wdata = '0; req_tag = 8'h30; req_valid = 1'b1; resp_ready = 1'b0;
    #1;
    n = 0;
    while (!m_req_ready && n < 20) begin @(negedge clk); n++; end
    chk({nm, " accept"}, 64'(m_req_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (extra) @(negedge clk);
    chk({nm, " pre sp_en"}, 64'(m_sp_en), 64'(pre_en));
    chk({nm, " pre resp_valid"}, 64'(m_resp_valid), 64'(pre_rv));
    #2 rst_l = 1'b0;
    #1;
    chk({nm, " rst sp_en"}, 64'(m_sp_en), 64'd0);
    chk({nm, " rst resp_valid"}, 64'(m_resp_valid), 64'd0);
    chk({nm, " rst req_ready"}, 64'(m_req_ready), 64'd0);
    repeat (2) @(negedge clk);
    rst_l = 1'b1;
    resp_ready = 1'b1;
    stale = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (m_resp_valid || m_sp_en) stale = 1'b1;
    end
    resp_ready = 1'b0;
    chk({nm, " no stale activity"}, 64'(stale), 64'd0);
    chk({nm, " idle req_ready"}, 64'(m_req_ready), 64'd1);
  endtask

  vec_t vecs [13];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0;
    sel = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = LEN_B;
    req_wdata = '0; req_tag = '0; resp_ready = 1'b0;

    //          dut wr  addr                  len    wdata                   tag    err        rdata                   lat spen stall
    vecs[0]  = mk(0, 1, BASE + 64'h10,        LEN_D, 64'hDEAD_BEEF_CAFE_F00D, 8'd3,  ERR_OK,    64'h0,                  2, 1, 0);
    vecs[1]  = mk(0, 0, BASE + 64'h10,        LEN_D, 64'h0,                   8'd4,  ERR_OK,    64'hDEAD_BEEF_CAFE_F00D, 3, 1, 0);
    vecs[2]  = mk(0, 0, BASE + 64'h10,        LEN_B, 64'h0,                   8'd5,  ERR_OK,    64'h0D,                 3, 1, 0);
    vecs[3]  = mk(0, 0, BASE + 64'h12,        LEN_H, 64'h0,                   8'd6,  ERR_OK,    64'hCAFE,               3, 1, 0);
    vecs[4]  = mk(0, 0, BASE - 64'h8,         LEN_D, 64'h0,                   8'd7,  ERR_RANGE, 64'h0,                  1, 0, 0);
    vecs[5]  = mk(0, 1, BASE + SPSZ - 64'h2,  LEN_W, 64'h1234_5678,           8'd8,  ERR_RANGE, 64'h0,                  1, 0, 0);
    vecs[6]  = mk(0, 0, BASE + 64'h6,         LEN_W, 64'h0,                   8'd9,  ERR_ALIGN, 64'h0,                  1, 0, 0);
    vecs[7]  = mk(0, 0, BASE + 64'h14,        LEN_W, 64'h0,                   8'd10, ERR_OK,    64'hDEAD_BEEF,          3, 1, 5);
    vecs[8]  = mk(0, 1, BASE + SPSZ - 64'h8,  LEN_D, 64'h0123_4567_89AB_CDEF, 8'd11, ERR_OK,    64'h0,                  2, 1, 0);
    vecs[9]  = mk(0, 0, BASE + SPSZ - 64'h8,  LEN_D, 64'h0,                   8'd12, ERR_OK,    64'h0123_4567_89AB_CDEF, 3, 1, 0);
    vecs[10] = mk(0, 0, BASE + SPSZ - 64'h4,  LEN_D, 64'h0,                   8'd13, ERR_RANGE, 64'h0,                  1, 0, 0);
    vecs[11] = mk(0, 0, 64'hFFFF_FFFF_FFFF_FFF8, LEN_D, 64'h0,                8'd14, ERR_RANGE, 64'h0,                  1, 0, 0);
    vecs[12] = mk(1, 0, BASE + SPSZ - 64'h8,  LEN_D, 64'h0,                   8'h21, ERR_OK,    64'hA6A5_DA5D_0300_7FF8, 5, 1, 0);

    // Reset values while held in reset
    rst_l = 1'b0;
    #3;
    chk("reset req_ready",  64'(if1.req_ready),  64'd0);
    chk("reset resp_valid", 64'(if1.resp_valid), 64'd0);
    chk("reset sp_en",      64'(sp_en1),         64'd0);
    chk("reset sp_write",   64'(sp_write1),      64'd0);
    chk("reset sp_addr",    sp_addr1,            64'd0);
    chk("reset resp_rdata", if1.resp_rdata,      64'd0);
    chk("reset err/tag",    64'({if1.resp_err, if1.resp_tag}), 64'd0);
    chk("reset dut3 ready", 64'(if3.req_ready),  64'd0);
    repeat (2) @(negedge clk);
    rst_l = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle req_ready dut1", 64'(if1.req_ready), 64'd1);
    chk("idle req_ready dut3", 64'(if3.req_ready), 64'd1);

    for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

    @(negedge clk);
    reset_mid(1'b1, 1, 1'b0, 1'b0, "rst in WAIT");
    @(negedge clk);
    reset_mid(1'b0, 0, 1'b1, 1'b0, "rst in ISSUE");
    @(negedge clk);
    reset_mid(1'b0, 2, 1'b0, 1'b1, "rst in RESP");

    // Controller still works normally after the resets
    @(negedge clk);
    run_vec(vecs[1], 101);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scratchpad_req_ctrl.md
Name: scratchpad_req_ctrl

Overview:
Request front-end that sits directly upstream of the scratchpad memory and drives its en/write/addr/len/wdata inputs. It accepts valid/ready memory requests from the core-side model and range- and alignment-checks them. Legal requests are issued to the scratchpad as single-cycle strobes; the block captures read data after a fixed latency and returns a tagged response over a valid/ready channel. Illegal requests never reach the scratchpad and are answered with an error code.

Parameters:
CHUNK_SIZE, 4096, bytes per scratchpad chunk
NUM_CHUNKS, 8, number of chunks; SP_SIZE = CHUNK_SIZE*NUM_CHUNKS (power of two)
SCRATCHPAD_BASE, 64'h0000_0000_0300_0000, first byte address of scratchpad
RD_LATENCY, 1, cycles from sp_en (read) to valid sp_rdata; legal range 1..4
TAG_W, 8, request/response tag width

Ports:
clk  in  1  clock
rst_l  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  request accepted when valid&ready
req_write  in  1  1=store, 0=load
req_addr  in  64  absolute byte address
req_len  in  2  00 byte, 01 half, 10 word, 11 double
req_wdata  in  64  store data, right-aligned
req_tag  in  TAG_W  opaque id, echoed on response
resp_valid  out  1  response present
resp_ready  in  1  response consumed when valid&ready
resp_rdata  out  64  load data, zero-extended to 64 bits; 0 for stores and errors
resp_err  out  2  00 ok, 01 out of range, 10 misaligned
resp_tag  out  TAG_W  tag of the completed request
sp_en  out  1  scratchpad access strobe
sp_write  out  1  scratchpad write enable
sp_addr  out  64  absolute address to scratchpad
sp_len  out  2  size to scratchpad
sp_wdata  out  64  store data to scratchpad
sp_rdata  in  64  scratchpad read data

Behaviour:
- Reset (rst_l=0, asynchronous): state=IDLE; req_ready, resp_valid, sp_en, sp_write=0; resp_rdata, resp_err, resp_tag, sp_addr, sp_len, sp_wdata=0. req_ready is forced to 0 while rst_l=0.
- FSM states: IDLE, ISSUE, WAIT, RESP. Exactly one request in flight.
- IDLE: req_ready=1. On req_valid: register write/addr/len/wdata/tag and compute err.
  - err!=00 -> RESP.
  - else -> ISSUE.
- Error check, using a 65-bit offset off = addr - SCRATCHPAD_BASE with bytes = 1<<len:
  - out of range if addr < SCRATCHPAD_BASE or off + bytes > SP_SIZE.
  - misaligned if addr & (bytes-1) != 0.
  - range takes priority when both apply.
- ISSUE: one cycle. sp_en=1; sp_write=req_write; sp_addr/len/wdata hold the registered values.
  - store -> RESP next cycle.
  - load -> WAIT with counter=RD_LATENCY-1.
- sp_* data outputs hold their values outside ISSUE; sp_en and sp_write are 0 outside ISSUE.
- WAIT: decrement the counter each cycle.
  - When the counter is 0, sample sp_rdata, mask it to the access size (byte [7:0], half [15:0], word [31:0], double all), zero-extend, and go to RESP.
  - With RD_LATENCY=1, sampling occurs the cycle after ISSUE.
- RESP: resp_valid=1 with rdata/err/tag stable until resp_ready. On handshake -> IDLE.
- Next request is accepted no earlier than the cycle after the response handshake (no overlap).
- Latency, req handshake to resp_valid:
  - error: 1 cycle
  - store: 2 cycles
  - load: 2+RD_LATENCY cycles
- resp_ready held 0 indefinitely: the block stalls in RESP with outputs stable and req_ready=0.
- Reset mid-operation: an in-flight access is abandoned and no response is produced.
- Boundary: addr = BASE+SP_SIZE-8 with double is legal; addr = BASE+SP_SIZE-4 with double is out of range. Wrap-around of addr+bytes past 2^64 counts as out of range (covered by the 65-bit arithmetic).

Decomposition:
- Shared package scratchpad_pkg: len encoding constants (LEN_B/H/W/D), resp_err encodings (ERR_OK/RANGE/ALIGN), FSM state enum, and the function len_bytes(len).
- One natural sub-module, sp_addr_check: combinational range/alignment checker. Inputs addr and len; output err. Parameterised by SCRATCHPAD_BASE and SP_SIZE.

Test Plan:
- Store then load, RD_LATENCY=1: write double 64'hDEAD_BEEF_CAFE_F00D at BASE+0x10, tag 3; then load double at the same address, tag 4. Required: responses err=00 with tags 3 and 4; load rdata=64'hDEAD_BEEF_CAFE_F00D; sp_en high exactly 1 cycle per request; load resp_valid 3 cycles after accept.
- Size masking: load byte at BASE+0x10 -> rdata 64'h0D; load half at BASE+0x12 -> 64'hCAFE (scratchpad model returns the shifted lane).
- Errors: load at BASE-8 -> err=01; store word at BASE+SP_SIZE-2 -> err=01; load word at BASE+0x6 -> err=10. Required in all cases: sp_en never asserted, rdata=0, resp_valid 1 cycle after accept.
- Backpressure: hold resp_ready=0 for 5 cycles on a load. Required: resp_* stable, req_ready=0, a second req_valid is not accepted until 1 cycle after the handshake.
- Latency parameter: RD_LATENCY=3 load double at BASE+SP_SIZE-8. Required: rdata sampled 3 cycles after sp_en, resp_valid 5 cycles after accept, err=00.
- Async reset: assert rst_l=0 mid-WAIT, between clock edges. Required: sp_en, resp_valid, req_ready go to 0 immediately; after release, state is IDLE, req_ready=1, and no stale response appears.
